k2_program_loader: RTL and testbench

Writable program store and loader for the K2 processor: the writer side of the instruction-fetch interface that `instruction_mem` serves read-only today. It accepts a 16-byte program over a byte-wide valid/ready stream and stores it in an internal RAM. It holds the core in reset while loading, then releases it and serves `ProgramAddress` fetches from the RAM. It replaces the fixed ROM in top-level program wrappers so that programs such as Fibonacci load at run time.

---
 rtl/k2_pkg.sv | 21 ++
 rtl/k2_program_loader_if.sv | 35 +++
 rtl/k2_prog_ram.sv | 38 +++
 rtl/k2_program_loader.sv | 168 ++++++++++++++++
 tb/tb_k2_program_loader.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/k2_pkg.sv
// k2_pkg: shared K2 program-store constants and loader state encoding.
// Config macro K2_LOADER_CHECKSUM_EN enables the CHECK/ERROR states in the loader.
`default_nettype none

package k2_pkg;

  localparam int K2_PROG_DEPTH = 16;
  localparam int K2_AW         = 4;
  localparam int K2_IW         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/k2_program_loader_if.sv
// k2_program_loader_if: byte load stream, fetch port and core-control signals.
// Config macro K2_LOADER_CHECKSUM_EN only changes the meaning of load_err.
`default_nettype none

interface k2_program_loader_if
  import k2_pkg::*;
#(
  parameter int AW = K2_AW,
  parameter int IW = K2_IW
);

  logic          load_req;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] ProgramAddress;
  logic [IW-1:0] instruction_data;
  logic          core_rst_n;
  logic          loaded;
  logic          load_err;
  logic [AW:0]   word_count;

  modport master (
    output load_req, in_data, in_valid, ProgramAddress,
    input  in_ready, instruction_data, core_rst_n, loaded, load_err, word_count
  );

  modport slave (
    input  load_req, in_data, in_valid, ProgramAddress,
    output in_ready, instruction_data, core_rst_n, loaded, load_err, word_count
  );

endinterface

`default_nettype wire

// File: rtl/k2_prog_ram.sv
// k2_prog_ram: DEPTH x IW program store, async clear, sync write, async read.
// Config macro K2_LOADER_CHECKSUM_EN has no effect on this module.
`default_nettype none

module k2_prog_ram
  import k2_pkg::*;
#(
  parameter int DEPTH = K2_PROG_DEPTH,
  parameter int AW    = K2_AW,
  parameter int IW    = K2_IW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [IW-1:0] i_wdata,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [IW-1:0] o_rdata
);

  logic [IW-1:0] r_mem [DEPTH];

  // Reset wipes the whole image so a half-loaded program can never run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/k2_program_loader.sv
// k2_program_loader: streams a 16-byte program into k2_prog_ram and gates K2 core reset.
// Config macro K2_LOADER_CHECKSUM_EN adds a trailing checksum byte plus CHECK/ERROR states.
`default_nettype none

module k2_program_loader
  import k2_pkg::*;
#(
  parameter int DEPTH = K2_PROG_DEPTH,
  parameter int AW    = K2_AW,
  parameter int IW    = K2_IW
) (
  input wire logic            clk,
  input wire logic            rst_n,
  k2_program_loader_if.slave  bus
);

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  loader_state_t r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_in_ready;
  logic          r_core_rst_n;
  logic          r_loaded;

  logic w_accept;
  logic w_full;
  logic w_we;
  logic w_enter_load;

  assign w_accept     = bus.in_valid & r_in_ready;
  assign w_full       = (r_count == C_FULL);
  assign w_we         = w_accept & ~w_full;
  assign w_enter_load = bus.load_req &
                        ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR));

`ifdef K2_LOADER_CHECKSUM_EN
  logic [IW-1:0] r_sum;
  logic [IW-1:0] r_csum;
  logic          r_load_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_loaded     <= 1'b0;
      r_sum        <= '0;
      r_csum       <= '0;
      r_load_err   <= 1'b0;
    end else if (w_enter_load) begin
      r_state      <= ST_LOAD;
      r_ptr        <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_loaded     <= 1'b0;
      r_sum        <= '0;
      r_load_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            // The byte after a full program is the checksum; it is never stored.
            if (w_full) begin
              r_csum     <= bus.in_data;
              r_in_ready <= 1'b0;
              r_state    <= ST_CHECK;
            end else begin
              r_ptr   <= r_ptr + AW'(1);
              r_count <= r_count + (AW+1)'(1);
              r_sum   <= r_sum + bus.in_data;
            end
          end
        end
        ST_CHECK: begin
          if (r_sum == r_csum) begin
            r_state      <= ST_RUN;
            r_core_rst_n <= 1'b1;
            r_loaded     <= 1'b1;
          end else begin
            r_state    <= ST_ERROR;
            r_load_err <= 1'b1;
          end
        end
        ST_IDLE, ST_RUN, ST_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load_err = r_load_err;
`else
  logic w_last;

  assign w_last = (r_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_loaded     <= 1'b0;
    end else if (w_enter_load) begin
      r_state      <= ST_LOAD;
      r_ptr        <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_loaded     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_ptr   <= r_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(1);
            // Last byte releases the core on the same edge that writes it.
            if (w_last) begin
              r_state      <= ST_RUN;
              r_in_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_loaded     <= 1'b1;
            end
          end
        end
        ST_IDLE, ST_RUN: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load_err = 1'b0;
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.loaded     = r_loaded;
  assign bus.word_count = r_count;

  k2_prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (bus.ProgramAddress),
    .o_rdata (bus.instruction_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_k2_program_loader.sv
// tb_k2_program_loader: randomized self-checking bench against a byte-array program model.
// Config macro K2_LOADER_CHECKSUM_EN selects checksum-byte loads and the checksum scenario.
`default_nettype none

module tb_k2_program_loader;
  import k2_pkg::*;

  typedef logic [7:0] prog_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  k2_program_loader_if #(.AW(K2_AW), .IW(K2_IW)) bus ();

  k2_program_loader #(
    .DEPTH (K2_PROG_DEPTH),
    .AW    (K2_AW),
    .IW    (K2_IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] model_mem [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.ProgramAddress = 4'(a);
      #1;
      total++;
      if (bus.instruction_data !== model_mem[a]) begin
        bad++;
        $display("FAIL %s addr=%0d got=%02h exp=%02h", tag, a, bus.instruction_data, model_mem[a]);
      end
    end
  endtask

  task automatic start_load();
    bus.load_req = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.load_req = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.loaded !== 1'b0 ||
        bus.word_count !== 5'd0 || bus.load_err !== 1'b0) begin
      bad++;
      $display("FAIL load_entry got rdy=%b crst=%b ld=%b wc=%0d err=%b exp 1 0 0 0 0",
               bus.in_ready, bus.core_rst_n, bus.loaded, bus.word_count, bus.load_err);
    end
  endtask

  // mode 0: back-to-back, 1: alternating valid, 2: random valid
  task automatic stream(input prog_t p, input int n, input int mode);
    int  i = 0;
    int  cyc = 0;
    bit  v, acc;
    while (i < n && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? p[i] : 8'($urandom);
      bus.ProgramAddress = 4'(i);
      #1;
      total++;
      if (bus.instruction_data !== model_mem[i]) begin
        bad++;
        $display("FAIL rd_during_wr addr=%0d got=%02h exp_old=%02h", i, bus.instruction_data, model_mem[i]);
      end
      acc = v && bus.in_ready;
      tick();
      cyc++;
      if (acc) begin
        model_mem[i] = p[i];
        i++;
        total++;
        if (bus.word_count !== 5'(i)) begin
          bad++;
          $display("FAIL word_count got=%0d exp=%0d", bus.word_count, i);
        end
      end
    end
    bus.in_valid = 1'b0;
    if (i < n) begin
      bad++;
      $display("FAIL stream_timeout accepted=%0d exp=%0d", i, n);
    end
  endtask

  // Completes a load started by start_load; csum_off != 0 corrupts the checksum.
  task automatic load_program(input prog_t p, input int mode, input logic [7:0] csum_off);
    int         s = 0;
    logic [7:0] csum;
    bit         exp_err;
    for (int k = 0; k < 16; k++) s += int'(p[k]);
    csum    = 8'(s) + csum_off;
    exp_err = 1'b0;
    stream(p, 16, mode);
`ifdef K2_LOADER_CHECKSUM_EN
    exp_err = (csum_off != 8'd0);
    total++;
    if (bus.in_ready !== 1'b1 || bus.word_count !== 5'd16 || bus.core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL await_csum got rdy=%b wc=%0d crst=%b exp 1 16 0",
               bus.in_ready, bus.word_count, bus.core_rst_n);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = csum;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || bus.core_rst_n !== 1'b0 || bus.loaded !== 1'b0) begin
      bad++;
      $display("FAIL check_state got rdy=%b crst=%b ld=%b exp 0 0 0",
               bus.in_ready, bus.core_rst_n, bus.loaded);
    end
    tick();
`endif
    total++;
    if (bus.core_rst_n !== !exp_err || bus.loaded !== !exp_err || bus.load_err !== exp_err ||
        bus.in_ready !== 1'b0 || bus.word_count !== 5'd16) begin
      bad++;
      $display("FAIL release got crst=%b ld=%b err=%b rdy=%b wc=%0d exp %b %b %b 0 16",
               bus.core_rst_n, bus.loaded, bus.load_err, bus.in_ready, bus.word_count,
               !exp_err, !exp_err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (bus.core_rst_n !== 1'b0 || bus.in_ready !== 1'b0 || bus.loaded !== 1'b0 ||
        bus.load_err !== 1'b0 || bus.word_count !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs got crst=%b rdy=%b ld=%b err=%b wc=%0d exp all 0",
               bus.core_rst_n, bus.in_ready, bus.loaded, bus.load_err, bus.word_count);
    end
    check_ram("reset_ram");
    // Bytes offered in IDLE must be dropped.
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = 8'($urandom_range(1, 255));
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || bus.word_count !== 5'd0 || bus.core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL idle_drop got rdy=%b wc=%0d crst=%b exp 0 0 0",
               bus.in_ready, bus.word_count, bus.core_rst_n);
    end
    check_ram("idle_drop_ram");
  endtask

  task automatic test_full_load();
    prog_t p;
    for (int k = 0; k < 16; k++) p[k] = 8'(8'h10 + k);
    start_load();
    load_program(p, 0, 8'd0);
    bus.ProgramAddress = 4'd5;
    #1;
    total++;
    if (bus.instruction_data !== 8'h15) begin
      bad++;
      $display("FAIL addr5 got=%02h exp=15", bus.instruction_data);
    end
    check_ram("full_load_ram");
    // Bytes offered in RUN must be dropped.
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.word_count !== 5'd16 || bus.loaded !== 1'b1 || bus.core_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL run_drop got wc=%0d ld=%b crst=%b exp 16 1 1",
               bus.word_count, bus.loaded, bus.core_rst_n);
    end
    check_ram("run_drop_ram");
  endtask

  task automatic test_throttled();
    prog_t p;
    for (int k = 0; k < 16; k++) p[k] = 8'(8'hA0 + k);
    start_load();
    load_program(p, 1, 8'd0);
    check_ram("throttled_ram");
  endtask

  task automatic test_reload();
    prog_t p;
    for (int k = 0; k < 16; k++) p[k] = 8'h55;
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    total++;
    if (bus.core_rst_n !== 1'b0 || bus.loaded !== 1'b0 || bus.word_count !== 5'd0 ||
        bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reload_entry got crst=%b ld=%b wc=%0d rdy=%b exp 0 0 0 1",
               bus.core_rst_n, bus.loaded, bus.word_count, bus.in_ready);
    end
    load_program(p, 0, 8'd0);
    check_ram("reload_ram");
  endtask

  task automatic test_random();
    prog_t p;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) p[k] = 8'($urandom);
      start_load();
      load_program(p, 2, 8'd0);
      check_ram("random_ram");
    end
  endtask

  task automatic test_reset_midload();
    prog_t p;
    for (int k = 0; k < 16; k++) p[k] = 8'($urandom_range(1, 255));
    start_load();
    stream(p, 7, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    tick();
    total++;
    if (bus.in_ready !== 1'b0 || bus.word_count !== 5'd0 || bus.core_rst_n !== 1'b0 ||
        bus.loaded !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset got rdy=%b wc=%0d crst=%b ld=%b exp 0 0 0 0",
               bus.in_ready, bus.word_count, bus.core_rst_n, bus.loaded);
    end
    check_ram("midload_ram");
  endtask

`ifdef K2_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    prog_t p;
    for (int k = 0; k < 16; k++) p[k] = 8'(k + 1);
    start_load();
    load_program(p, 0, 8'd0);
    check_ram("csum_good_ram");
    start_load();
    load_program(p, 0, 8'd1);
    tick();
    total++;
    if (bus.load_err !== 1'b1 || bus.core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL csum_err_hold got err=%b crst=%b exp 1 0", bus.load_err, bus.core_rst_n);
    end
    start_load();
    load_program(p, 2, 8'd0);
  endtask
`endif

  initial begin
    bus.load_req       = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_data        = 8'h00;
    bus.ProgramAddress = 4'd0;
    test_reset();
    test_full_load();
    test_throttled();
    test_reload();
    test_random();
`ifdef K2_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
